// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial block family.
//
// Contents:
//   serial_state_e : word-sequencing states (IDLE, START, SHIFT) shared by
//                    serial transmitters and future serial consumers.
//   cnt_width()    : width of a down-counter that must hold values 0..width-1;
//                    never narrower than one bit so WIDTH=1 still gets a
//                    legal vector.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } serial_state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    if (width <= 1) begin
      w = 1;
    end else begin
      w = $clog2(width);
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_operand_transmitter_msb_first_if.sv
// Operand-pair / serial-stream bundle for serial_operand_transmitter_msb_first.
//
// Signals:
//   in_valid, in_a, in_b : operand pair offered by the producer
//   in_ready             : transmitter accepts the pair this cycle
//   start                : one-cycle pulse before the first bit of a word
//   a, b                 : current serial bits, MSB first
//   bit_valid            : a/b carry a live bit
//   last                 : current bit is the LSB
//   busy                 : a word is in flight
//
// Modports:
//   master : the operand producer (drives the handshake, observes the stream)
//   slave  : the transmitter (accepts operands, drives the stream)
interface serial_operand_transmitter_msb_first_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             start;
  logic             a;
  logic             b;
  logic             bit_valid;
  logic             last;
  logic             busy;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    input  in_ready,
    input  start,
    input  a,
    input  b,
    input  bit_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    output in_ready,
    output start,
    output a,
    output b,
    output bit_valid,
    output last,
    output busy
  );

endinterface

// File: rtl/serial_shift_reg_msb_first.sv
// Parallel-load, left-shifting register exposing its MSB as a serial output.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears contents)
//   load  : capture din this cycle (wins over shift)
//   shift : shift left by one, zero-filling the LSB
//   din   : parallel load value
//   msb   : current most significant bit
module serial_shift_reg_msb_first #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load has priority so a back-to-back word captured in the final bit
  // cycle replaces the exhausted contents rather than shifting them.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_operand_transmitter_msb_first.sv
// Serialises a pair of WIDTH-bit operands into two synchronised bit streams,
// most significant bit first. Each word is preceded by a one-cycle start pulse
// so a downstream serial consumer can clear its state (consumer reset is
// rst | start); the final bit is flagged with last.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of serial_operand_transmitter_msb_first_if
//         (in_valid/in_ready/in_a/in_b handshake in,
//          start/a/b/bit_valid/last/busy stream out)
//
// Timing: handshake at edge E gives start in cycle E+1, MSB in E+2 and the
// LSB (last) in E+1+WIDTH. A new pair may be accepted in the last cycle, so
// sustained throughput is one word per WIDTH+1 cycles.
module serial_operand_transmitter_msb_first
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                                  clk,
  input logic                                  rst,
  serial_operand_transmitter_msb_first_if.slave bus
);

  localparam int unsigned CntWidth = cnt_width(WIDTH);

  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t CntLast = cnt_t'(WIDTH - 1);

  serial_state_e state_q;
  serial_state_e state_d;
  cnt_t          cnt_q;
  cnt_t          cnt_d;

  logic in_ready;
  logic handshake;
  logic cnt_zero;
  logic shift_en;
  logic msb_a;
  logic msb_b;

  assign cnt_zero = (cnt_q == '0);

  // Ready in IDLE and in the final bit cycle only; held low during reset so
  // nothing is accepted on the reset edge.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && cnt_zero));
  assign handshake = bus.in_valid && in_ready;
  assign shift_en  = (state_q == SHIFT);

  serial_shift_reg_msb_first #(
    .WIDTH (WIDTH)
  ) u_sr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (handshake),
    .shift (shift_en),
    .din   (bus.in_a),
    .msb   (msb_a)
  );

  serial_shift_reg_msb_first #(
    .WIDTH (WIDTH)
  ) u_sr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (handshake),
    .shift (shift_en),
    .din   (bus.in_b),
    .msb   (msb_b)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = START;
        end
      end
      START: begin
        cnt_d   = CntLast;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_zero) begin
          // Leaving on the LSB; the counter never wraps below zero.
          state_d = handshake ? START : IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; everything except in_ready is a function of the registered state.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.start     = 1'b0;
    bus.a         = 1'b0;
    bus.b         = 1'b0;
    bus.bit_valid = 1'b0;
    bus.last      = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      START: begin
        bus.start = 1'b1;
        bus.busy  = 1'b1;
      end
      SHIFT: begin
        bus.a         = msb_a;
        bus.b         = msb_b;
        bus.bit_valid = 1'b1;
        bus.last      = cnt_zero;
        bus.busy      = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
